// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter between two requesters sharing one
// single-port, full-word-write, async-read data RAM. Partial stores are
// turned into read-modify-write sequences.
module ram_arbiter #(
  parameter int depth = 1024,
  localparam int AW = $clog2(depth)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  input  logic [3:0]    p0_be,
  output logic          p0_gnt,
  output logic          p0_ack,
  output logic [31:0]   p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  input  logic [3:0]    p1_be,
  output logic          p1_gnt,
  output logic          p1_ack,
  output logic [31:0]   p1_rdata,
  output logic          MemWrite,
  output logic          MemRead,
  output logic [AW-1:0] address,
  output logic [31:0]   write_data,
  input  logic [31:0]   read_data
);

  typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;

  state_t        state;
  logic          rr_last;
  logic          port_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   rdata_q;

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_be;

  // Grant only from IDLE and never while reset is held; ties go to the
  // port that was not granted last.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!RESET && state == IDLE) begin
      p0_gnt = p0_req && (!p1_req || rr_last);
      p1_gnt = p1_req && (!p0_req || !rr_last);
    end
  end

  // Request fields of whichever port is being granted this cycle.
  always_comb begin
    sel_we    = p1_gnt ? p1_we    : p0_we;
    sel_addr  = p1_gnt ? p1_addr  : p0_addr;
    sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
    sel_be    = p1_gnt ? p1_be    : p0_be;
  end

  // RAM pins: strobes only in active states and forced low under reset.
  always_comb begin
    MemRead    = !RESET && (state == READ || state == MERGE);
    MemWrite   = !RESET && (state == WRITE) && (|be_q);
    address    = addr_q;
    write_data = wdata_q;
  end

  assign p0_rdata = rdata_q;
  assign p1_rdata = rdata_q;

  // Access sequencer: latch on grant, then read, merge and/or write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      port_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      p0_ack  <= 1'b0;
      p1_ack  <= 1'b0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (p0_gnt || p1_gnt) begin
            port_q  <= p1_gnt;
            rr_last <= p1_gnt;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            be_q    <= sel_be;
            if (!sel_we)
              state <= READ;
            else if (sel_be == 4'b1111 || sel_be == 4'b0000)
              state <= WRITE;
            else
              state <= MERGE;
          end
        end
        READ: begin
          rdata_q <= read_data;
          p0_ack  <= !port_q;
          p1_ack  <= port_q;
          state   <= IDLE;
        end
        MERGE: begin
          for (int unsigned i = 0; i < 4; i++) begin
            if (!be_q[i])
              wdata_q[8*i +: 8] <= read_data[8*i +: 8];
          end
          be_q  <= '1;
          state <= WRITE;
        end
        WRITE: begin
          p0_ack <= !port_q;
          p1_ack <= port_q;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: transaction-level reference model of the two-port RAM
// arbiter with a behavioural RAM attached to the DUT pins.
module tb_ram_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [9:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic [3:0]  p0_be, p1_be;
  logic        p0_gnt, p0_ack, p1_gnt, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic        MemWrite, MemRead;
  logic [9:0]  address;
  logic [31:0] write_data, read_data;

  logic [31:0] ram [0:1023];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;

  logic [31:0] ref_mem [16];
  int          last_win;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic        op_we    [2];
  logic [9:0]  op_addr  [2];
  logic [31:0] op_wdata [2];
  logic [3:0]  op_be    [2];

  always #5 CLK = ~CLK;

  ram_arbiter #(.depth(1024)) dut (
    .CLK(CLK), .RESET(RESET),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_be(p0_be), .p0_gnt(p0_gnt), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_be(p1_be), .p1_gnt(p1_gnt), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .MemWrite(MemWrite), .MemRead(MemRead), .address(address),
    .write_data(write_data), .read_data(read_data)
  );

  // Behavioural RAM: async read, full-word synchronous write, plus a
  // backdoor port used only for preloading during reset.
  always @(posedge CLK) begin
    if (MemWrite) ram[address] <= write_data;
    else if (bd_we) ram[bd_addr] <= bd_data;
  end
  assign read_data = ram[address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (new_w & mask) | (old_w & ~mask);
  endfunction

  function automatic int op_latency(input logic we, input logic [3:0] be);
    if (!we) return 2;
    if (be == 4'b1111 || be == 4'b0000) return 2;
    return 3;
  endfunction

  // Issue the ops in op_* for the enabled ports (entered just after a
  // rising edge with the DUT idle) and check grant/ack timing, read data,
  // and each RAM write against a schedule derived from the latency rules.
  task automatic run_ops(input bit en0, input bit en1);
    bit          en [2];
    int          order [2];
    int          g [2];
    int          a [2];
    logic [31:0] exp_rd [2];
    logic [31:0] exp_wd [2];
    int          n, t, endc, nwr, nwr_exp, wp;
    logic [3:0]  exp_hs;
    en[0] = en0; en[1] = en1;
    g[0] = -10; g[1] = -10; a[0] = -10; a[1] = -10;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_wd[0] = '0; exp_wd[1] = '0;
    if (en0 && en1) begin
      order[0] = (last_win == 1) ? 0 : 1;
      order[1] = 1 - order[0];
      n = 2;
    end else begin
      order[0] = en0 ? 0 : 1;
      order[1] = 0;
      n = 1;
    end
    t = 0;
    nwr_exp = 0;
    for (int j = 0; j < n; j++) begin
      int p;
      p = order[j];
      g[p] = t;
      a[p] = t + op_latency(op_we[p], op_be[p]);
      t = a[p];
      if (!op_we[p]) begin
        exp_rd[p] = ref_mem[op_addr[p][3:0]];
      end else if (op_be[p] != 4'b0000) begin
        exp_wd[p] = merge_word(ref_mem[op_addr[p][3:0]], op_wdata[p], op_be[p]);
        ref_mem[op_addr[p][3:0]] = exp_wd[p];
        nwr_exp++;
      end
      last_win = p;
    end
    endc = t;

    p0_req = en0; p0_we = op_we[0]; p0_addr = op_addr[0]; p0_wdata = op_wdata[0]; p0_be = op_be[0];
    p1_req = en1; p1_we = op_we[1]; p1_addr = op_addr[1]; p1_wdata = op_wdata[1]; p1_be = op_be[1];

    nwr = 0;
    for (int k = 0; k <= endc; k++) begin
      @(negedge CLK);
      exp_hs = {en[1] && g[1] == k, en[0] && g[0] == k, en[1] && a[1] == k, en[0] && a[0] == k};
      check("gnt1_gnt0_ack1_ack0", 32'({p1_gnt, p0_gnt, p1_ack, p0_ack}), 32'(exp_hs));
      for (int p = 0; p < 2; p++) begin
        if (en[p] && a[p] == k && !op_we[p])
          check(p == 0 ? "p0_rdata" : "p1_rdata", p == 0 ? p0_rdata : p1_rdata, exp_rd[p]);
      end
      if (MemWrite) begin
        nwr++;
        wp = -1;
        for (int p = 0; p < 2; p++)
          if (en[p] && op_we[p] && a[p] == k + 1) wp = p;
        if (wp < 0) begin
          check("write_timing", 32'(MemWrite), 32'd0);
        end else begin
          check("wr_address", 32'(address), 32'(op_addr[wp]));
          check("wr_data", write_data, exp_wd[wp]);
        end
      end
      @(posedge CLK); #1;
      if (en[0] && g[0] == k) p0_req = 1'b0;
      if (en[1] && g[1] == k) p1_req = 1'b0;
    end
    check("write_count", 32'(nwr), 32'(nwr_exp));
  endtask

  task automatic set_op(input int p, input logic we, input logic [9:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    op_we[p] = we; op_addr[p] = addr; op_wdata[p] = wdata; op_be[p] = be;
  endtask

  initial begin
    RESET = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_be = '0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_be = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;

    // Reset with both ports requesting; preload RAM through the backdoor.
    for (int i = 0; i < 16; i++) begin
      bd_we = 1'b1; bd_addr = 10'(i); bd_data = ref_mem[i];
      @(negedge CLK);
      if (i < 2) begin
        check("rst_gnt", 32'({p1_gnt, p0_gnt}), 32'd0);
        check("rst_mem_strobes", 32'({MemWrite, MemRead}), 32'd0);
      end
      if (i == 1) begin
        check("rst_acks", 32'({p1_ack, p0_ack}), 32'd0);
        check("rst_address", 32'(address), 32'd0);
      end
      @(posedge CLK); #1;
    end
    bd_we = 1'b0;
    RESET = 1'b0;
    last_win = 1;

    // Both loads from reset: p0 first, then p1 back-to-back; repeat.
    set_op(0, 1'b0, 10'd1, '0, 4'b0000);
    set_op(1, 1'b0, 10'd2, '0, 4'b0000);
    run_ops(1, 1);
    run_ops(1, 1);

    // Full-word store then load back.
    set_op(0, 1'b1, 10'd5, 32'hDEADBEEF, 4'b1111);
    run_ops(1, 0);
    set_op(0, 1'b0, 10'd5, '0, 4'b0000);
    run_ops(1, 0);

    // Partial store on p1 (read-modify-write) then load.
    set_op(1, 1'b1, 10'd5, 32'h0000AA00, 4'b0010);
    run_ops(0, 1);
    set_op(1, 1'b0, 10'd5, '0, 4'b0000);
    run_ops(0, 1);
    check("rmw_result", ram[5], 32'hDEADAAEF);

    // No-op store: acks, no write.
    set_op(0, 1'b1, 10'd5, 32'h12345678, 4'b0000);
    run_ops(1, 0);
    set_op(0, 1'b0, 10'd5, '0, 4'b0000);
    run_ops(1, 0);

    // Reset landing in MERGE aborts the partial store.
    set_op(0, 1'b1, 10'd7, 32'h11223344, 4'b1111);
    run_ops(1, 0);
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 10'd7; p0_wdata = 32'hAABBCCDD; p0_be = 4'b0110;
    @(negedge CLK);
    check("abort_gnt", 32'({p1_gnt, p0_gnt}), 32'd1);
    @(posedge CLK); #1;
    p0_req = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    check("abort_strobes", 32'({MemWrite, MemRead}), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    last_win = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("abort_quiet", 32'({MemWrite, p1_ack, p0_ack}), 32'd0);
      @(posedge CLK); #1;
    end
    check("abort_ram", ram[7], 32'h11223344);
    set_op(0, 1'b0, 10'd7, '0, 4'b0000);
    run_ops(1, 0);

    // Randomized single and contending transactions.
    for (int it = 0; it < 60; it++) begin
      bit e0, e1;
      e0 = 1'($urandom_range(0, 1));
      e1 = e0 ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int p = 0; p < 2; p++) begin
        logic [3:0] be;
        case ($urandom_range(0, 3))
          0:       be = 4'b0000;
          1:       be = 4'b1111;
          default: be = 4'($urandom);
        endcase
        set_op(p, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom, be);
      end
      run_ops(e0, e1);
    end

    for (int i = 0; i < 16; i++) check("final_ram", ram[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
